// File: rtl/myproject_acc_requant_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | myproject_acc_requant_if: product-in / result-out bus bundle      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface myproject_acc_requant_if #(
  parameter int IN_WIDTH  = 58,
  parameter int ACC_WIDTH = 64,
  parameter int OUT_WIDTH = 16
);
  logic                 prod_valid;
  logic [IN_WIDTH-1:0]  prod_data;
  logic                 prod_last;
  logic [ACC_WIDTH-1:0] bias;
  logic                 in_ready;
  logic                 res_valid;
  logic [OUT_WIDTH-1:0] res_data;
  logic                 res_ready;
  logic                 res_sat;
  logic                 overrun;

  modport master (
    output prod_valid, prod_data, prod_last, bias, res_ready,
    input  in_ready, res_valid, res_data, res_sat, overrun
  );

  modport slave (
    input  prod_valid, prod_data, prod_last, bias, res_ready,
    output in_ready, res_valid, res_data, res_sat, overrun
  );
endinterface
`default_nettype wire

// File: rtl/myproject_acc_requant.sv
`default_nettype none
// +------------------------------------------------------------------+
// | myproject_acc_requant: dot-product accumulator with round/requant |
// | Option: MYPROJECT_ACC_REQUANT_SAT_EN (clamp instead of wrap)      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module myproject_acc_requant #(
  parameter int IN_WIDTH   = 58,
  parameter int ACC_WIDTH  = 64,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 8
) (
  input wire clk,
  input wire reset,
  input wire ce,
  myproject_acc_requant_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam logic [ACC_WIDTH-1:0] c_half = ACC_WIDTH'(1) << (FRAC_SHIFT - 1);
`ifdef MYPROJECT_ACC_REQUANT_SAT_EN
  localparam logic [OUT_WIDTH-1:0] c_out_max = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] c_out_min = {1'b1, {(OUT_WIDTH-1){1'b0}}};
`endif

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [OUT_WIDTH-1:0]   res_data_q, res_data_d;
  logic                   res_sat_q, res_sat_d;
  logic                   overrun_q, overrun_d;

  logic                   w_in_ready;
  logic                   w_accept;
  logic [ACC_WIDTH-1:0]   w_term;
  logic [ACC_WIDTH-1:0]   w_sum;
  logic [ACC_WIDTH-1:0]   w_rounded;
  logic signed [ACC_WIDTH-1:0] w_r;

  assign w_in_ready = (state_q == IDLE) || (state_q == ACC);
  assign w_accept   = ce & bus.prod_valid & w_in_ready;
  assign w_term     = {{(ACC_WIDTH-IN_WIDTH){bus.prod_data[IN_WIDTH-1]}}, bus.prod_data};
  // The first term of a dot product starts from bias rather than the stale sum.
  assign w_sum      = ((state_q == IDLE) ? bus.bias : acc_q) + w_term;
  assign w_rounded  = acc_q + c_half;
  assign w_r        = $signed(w_rounded) >>> FRAC_SHIFT;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    res_data_d = res_data_q;
    res_sat_d  = res_sat_q;
    overrun_d  = overrun_q | (ce & bus.prod_valid & ~w_in_ready);
    case (state_q)
      IDLE, ACC: begin
        if (w_accept) begin
          acc_d   = w_sum;
          state_d = bus.prod_last ? ROUND : ACC;
        end
      end
      ROUND: begin
        if (ce) begin
`ifdef MYPROJECT_ACC_REQUANT_SAT_EN
          if ((&w_r[ACC_WIDTH-1:OUT_WIDTH-1]) || ~(|w_r[ACC_WIDTH-1:OUT_WIDTH-1])) begin
            res_data_d = w_r[OUT_WIDTH-1:0];
            res_sat_d  = 1'b0;
          end else begin
            res_data_d = w_r[ACC_WIDTH-1] ? c_out_min : c_out_max;
            res_sat_d  = 1'b1;
          end
`else
          res_data_d = OUT_WIDTH'(w_r);
          res_sat_d  = 1'b0;
`endif
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Result handshake is decoupled from the upstream pipeline enable.
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      res_data_q <= '0;
      res_sat_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      res_data_q <= res_data_d;
      res_sat_q  <= res_sat_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.res_valid = (state_q == HOLD);
  assign bus.res_data  = res_data_q;
  assign bus.res_sat   = res_sat_q;
  assign bus.overrun   = overrun_q;

endmodule
`default_nettype wire
